// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. Each requester
//   presents an operation (a, b, ctrl) with a valid/ready handshake; the
//   arbiter grants round-robin, registers the accepted operands and drives
//   the shared ALU from those registers. One cycle later the ALU result is
//   captured and returned on a single response channel tagged with the
//   requester id.
//
// Parameters
//   WIDTH      operand/result width (must match the shared ALU)
//   PRIO_INIT  requester holding priority after reset (0 or 1)
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req0_* / req1_*              requester channels: valid, ready, a, b, ctrl
//   alu_a, alu_b, alu_ctrl       operands/control to the shared ALU
//   alu_out, alu_zero            ALU result and zero flag (combinational)
//   rsp_valid, rsp_ready         response handshake
//   rsp_id                       requester the response belongs to
//   rsp_data, rsp_zero           captured ALU result and zero flag
//   rsp_illegal                  the ctrl code was outside the defined set
//   busy                         an operation is in flight (not IDLE)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Highest defined ALU control code; anything above is flagged illegal.
  localparam logic [3:0] CTRL_MAX   = 4'b1001;
  localparam logic       PRIO_RESET = (PRIO_INIT != 0);

  state_t           state_reg;
  state_t           state_next;
  logic             prio_reg;

  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [3:0]       op_ctrl_reg;
  logic             op_id_reg;

  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_zero_reg;
  logic             rsp_illegal_reg;
  logic             rsp_id_reg;

  logic             idle;
  logic             grant_id;
  logic             accept;
  logic             capture;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_ctrl;

  // -------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on contention prio decides.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_reg;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign idle = (state_reg == IDLE);

  // Gated with reset_n so no handshake is advertised while reset is held.
  assign req0_ready = reset_n & idle & req0_valid & ~grant_id;
  assign req1_ready = reset_n & idle & req1_valid &  grant_id;
  assign accept     = req0_ready | req1_ready;

  // Payload of the granted requester.
  always_comb begin
    sel_a    = req0_a;
    sel_b    = req0_b;
    sel_ctrl = req0_ctrl;
    if (grant_id) begin
      sel_a    = req1_a;
      sel_b    = req1_b;
      sel_ctrl = req1_ctrl;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: IDLE -> EXEC -> RESP -> IDLE
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        // ALU has had a full cycle on the registered operands.
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Round-robin priority: the requester just served yields to the other.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_reg <= PRIO_RESET;
    end else if (accept) begin
      prio_reg <= ~grant_id;
    end
  end

  // -------------------------------------------------------------------------
  // Operand registers. They only load on accept, so the ALU inputs hold
  // steady through EXEC and RESP and keep the last operation in IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      op_ctrl_reg <= '0;
      op_id_reg   <= 1'b0;
    end else if (accept) begin
      op_a_reg    <= sel_a;
      op_b_reg    <= sel_b;
      op_ctrl_reg <= sel_ctrl;
      op_id_reg   <= grant_id;
    end
  end

  // -------------------------------------------------------------------------
  // Response registers, loaded once in EXEC and stable until the next
  // operation reaches EXEC.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_reg    <= '0;
      rsp_zero_reg    <= 1'b0;
      rsp_illegal_reg <= 1'b0;
      rsp_id_reg      <= 1'b0;
    end else if (capture) begin
      rsp_data_reg    <= alu_out;
      rsp_zero_reg    <= alu_zero;
      rsp_illegal_reg <= (op_ctrl_reg > CTRL_MAX);
      rsp_id_reg      <= op_id_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign alu_a       = op_a_reg;
  assign alu_b       = op_b_reg;
  assign alu_ctrl    = op_ctrl_reg;

  assign rsp_valid   = (state_reg == RESP);
  assign rsp_id      = rsp_id_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_zero    = rsp_zero_reg;
  assign rsp_illegal = rsp_illegal_reg;
  assign busy        = ~idle;

endmodule
